// File: rtl/cacheline_adaptor.sv
// Cache-line to memory-burst adaptor: splits a line write into n_beats beats and assembles read beats into a line.
// Defining ADAPTOR_PROTOCOL_CHECK_EN adds a sticky protocol-error checker on proto_err.
module cacheline_adaptor #(
    parameter int s_line  = 256,
    parameter int s_burst = 64,
    parameter int n_beats = s_line / s_burst
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               line_read,
    input  logic               line_write,
    input  logic [31:0]        line_address,
    input  logic [s_line-1:0]  line_wdata,
    output logic [s_line-1:0]  line_rdata,
    output logic               line_resp,

    input  logic [s_burst-1:0] burst_rdata,
    input  logic               burst_resp,
    output logic [s_burst-1:0] burst_wdata,
    output logic [31:0]        burst_address,
    output logic               burst_read,
    output logic               burst_write,

    output logic               proto_err
);

    localparam int              CntW      = (n_beats > 1) ? $clog2(n_beats) : 1;
    localparam int              OffW      = $clog2(s_line / 8);
    localparam logic [31:0]     AlignMask = ~((32'd1 << OffW) - 32'd1);
    localparam logic [CntW-1:0] LastBeat  = CntW'(n_beats - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [31:0]         addr_q, addr_d;
    logic [s_line-1:0]   wdata_q, wdata_d;
    logic [s_line-1:0]   rdata_q, rdata_d;
    logic                lastBeat;

    assign lastBeat = (cnt_q == LastBeat);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Request inputs are sampled only in IDLE; everything after that works from the latched copies.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (line_write || line_read) begin
                    state_d = line_write ? WRITE : READ;
                    addr_d  = line_address & AlignMask;
                    wdata_d = line_wdata;
                    cnt_d   = '0;
                end
            end
            READ: begin
                if (burst_resp) begin
                    rdata_d[cnt_q*s_burst +: s_burst] = burst_rdata;
                    if (lastBeat) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                if (burst_resp) begin
                    if (lastBeat) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign burst_read    = (state_q == READ);
    assign burst_write   = (state_q == WRITE);
    assign line_resp     = (state_q == DONE);
    assign burst_address = addr_q;
    assign burst_wdata   = wdata_q[cnt_q*s_burst +: s_burst];
    assign line_rdata    = rdata_q;

`ifdef ADAPTOR_PROTOCOL_CHECK_EN
    logic err_q, err_d, errEvent;

    // Violations: stray beat handshakes outside a burst, ambiguous requests, or a request dropped mid-burst.
    always_comb begin
        errEvent = 1'b0;
        case (state_q)
            IDLE:    errEvent = burst_resp || (line_read && line_write);
            READ:    errEvent = !line_read;
            WRITE:   errEvent = !line_write;
            DONE:    errEvent = burst_resp;
            default: errEvent = 1'b0;
        endcase
        err_d = err_q | errEvent;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign proto_err = err_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Randomized scoreboard bench for cacheline_adaptor: a driver queues expected beats/lines,
// an independent negedge monitor pops and compares them against what the DUT presents.
module tb_cacheline_adaptor;

    localparam int LINE  = 256;
    localparam int BURST = 64;
    localparam int NB    = LINE / BURST;
    localparam int BOUND = 50;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             line_read = 1'b0;
    logic             line_write = 1'b0;
    logic [31:0]      line_address = '0;
    logic [LINE-1:0]  line_wdata = '0;
    logic [LINE-1:0]  line_rdata;
    logic             line_resp;
    logic [BURST-1:0] burst_rdata = '0;
    logic             burst_resp = 1'b0;
    logic [BURST-1:0] burst_wdata;
    logic [31:0]      burst_address;
    logic             burst_read;
    logic             burst_write;
    logic             proto_err;

    typedef struct {
        bit              isWrite;
        logic [31:0]     addr;
        logic [LINE-1:0] line;
    } txn_t;

    txn_t             txnQ[$];
    logic [BURST-1:0] beatQ[$];
    int               tests = 0;
    int               fails = 0;
    bit               expectErr;
    logic [LINE-1:0]  held;
    logic [LINE-1:0]  wd;

    cacheline_adaptor #(.s_line(LINE), .s_burst(BURST)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .line_read     (line_read),
        .line_write    (line_write),
        .line_address  (line_address),
        .line_wdata    (line_wdata),
        .line_rdata    (line_rdata),
        .line_resp     (line_resp),
        .burst_rdata   (burst_rdata),
        .burst_resp    (burst_resp),
        .burst_wdata   (burst_wdata),
        .burst_address (burst_address),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .proto_err     (proto_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [LINE-1:0] act, input logic [LINE-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [LINE-1:0] randLine();
        logic [LINE-1:0] r;
        r = '0;
        for (int k = 0; k < LINE / 32; k++) r = {r[LINE-33:0], 32'($urandom)};
        return r;
    endfunction

    function automatic logic [31:0] alignAddr(input logic [31:0] a);
        return (a / (LINE / 8)) * (LINE / 8);
    endfunction

    // Monitor: write beats are compared every cycle they are presented, lines at each completion pulse.
    always @(negedge clk) begin : monitor
        txn_t t;
        if (rst_n) begin
            if (burst_write) begin
                if (beatQ.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL wbeat_unexpected: got burst_write=1 required no write in progress");
                end else begin
                    checkOutput("burst_wdata", burst_wdata, beatQ[0]);
                    if (burst_resp) void'(beatQ.pop_front());
                end
            end
            if (line_resp) begin
                if (txnQ.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL resp_unexpected: got line_resp=1 required 0");
                end else begin
                    t = txnQ.pop_front();
                    checkOutput("resp_address", burst_address, t.addr);
                    if (t.isWrite) checkOutput("write_beats_left", beatQ.size(), 0);
                    else           checkOutput("line_rdata", line_rdata, t.line);
                end
            end
        end
    end

    // Drives one complete line transaction; beat gaps drawn from [gapMin, gapMax] cycles.
    task automatic applyStimulus(input bit isWrite, input bit both, input logic [31:0] addr,
                                 input logic [LINE-1:0] wdata, input bit fixedBeats,
                                 input int gapMin, input int gapMax);
        logic [LINE-1:0]  rline;
        logic [BURST-1:0] beat;
        int               waited;
        int               gap;
        txn_t             t;
        rline        = '0;
        waited       = 0;
        line_address = addr;
        line_wdata   = wdata;
        line_write   = isWrite || both;
        line_read    = !isWrite || both;
        if (isWrite) begin
            for (int i = 0; i < NB; i++) beatQ.push_back(wdata[i*BURST +: BURST]);
            t.isWrite = 1'b1;
            t.addr    = alignAddr(addr);
            t.line    = '0;
            txnQ.push_back(t);
        end
        do begin
            @(posedge clk); #1;
            waited++;
        end while (!(burst_read || burst_write) && waited < BOUND);
        checkOutput("accept_latency", waited, 1);
        if (waited >= BOUND) begin
            line_read  = 1'b0;
            line_write = 1'b0;
            return;
        end
        for (int i = 0; i < NB; i++) begin
            gap = $urandom_range(gapMax, gapMin);
            for (int g = 0; g < gap; g++) begin
                line_address = $urandom;
                line_wdata   = randLine();
                burst_rdata  = {$urandom, $urandom};
                checkOutput("burst_read", burst_read, !isWrite);
                checkOutput("burst_write", burst_write, isWrite);
                @(posedge clk); #1;
            end
            beat = fixedBeats ? {8{8'(8'h11 * (i + 1))}} : {$urandom, $urandom};
            if (!isWrite) rline = rline | (LINE'(beat) << (i * BURST));
            burst_rdata  = beat;
            burst_resp   = 1'b1;
            line_address = $urandom;
            line_wdata   = randLine();
            checkOutput("burst_read", burst_read, !isWrite);
            checkOutput("burst_write", burst_write, isWrite);
            checkOutput("burst_address", burst_address, alignAddr(addr));
            @(posedge clk); #1;
            burst_resp = 1'b0;
        end
        if (!isWrite) begin
            t.isWrite = 1'b0;
            t.addr    = alignAddr(addr);
            t.line    = rline;
            txnQ.push_back(t);
        end
        checkOutput("line_resp_pulse", line_resp, 1);
        line_read  = 1'b0;
        line_write = 1'b0;
        @(posedge clk); #1;
        checkOutput("line_resp_single", line_resp, 0);
        checkOutput("idle_no_burst", {burst_read, burst_write}, 0);
    endtask

    initial begin
`ifdef ADAPTOR_PROTOCOL_CHECK_EN
        expectErr = 1'b1;
`else
        expectErr = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_line_resp", line_resp, 0);
        checkOutput("rst_burst_rw", {burst_read, burst_write}, 0);
        checkOutput("rst_burst_address", burst_address, 0);
        checkOutput("rst_line_rdata", line_rdata, 0);
        checkOutput("rst_burst_wdata", burst_wdata, 0);
        checkOutput("rst_proto_err", proto_err, 0);
        rst_n = 1'b1;

        applyStimulus(1'b0, 1'b0, 32'h0000_1234, '0, 1'b1, 0, 0);
        checkOutput("dir_rdata_hold", line_rdata,
                    {64'h4444444444444444, 64'h3333333333333333,
                     64'h2222222222222222, 64'h1111111111111111});
        checkOutput("dir_address", burst_address, 32'h0000_1220);

        wd = {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC,
              64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA};
        applyStimulus(1'b1, 1'b0, $urandom, wd, 1'b0, 1, 1);
        checkOutput("proto_clean", proto_err, 0);

        held        = line_rdata;
        burst_rdata = {$urandom, $urandom};
        burst_resp  = 1'b1;
        @(posedge clk); #1;
        burst_resp = 1'b0;
        checkOutput("stray_no_burst", {burst_read, burst_write, line_resp}, 0);
        checkOutput("stray_rdata_kept", line_rdata, held);
        checkOutput("stray_proto_err", proto_err, expectErr);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("rst_clears_err", proto_err, 0);

        applyStimulus(1'b1, 1'b1, $urandom, randLine(), 1'b0, 0, 2);
        checkOutput("both_proto_err", proto_err, expectErr);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        line_address = $urandom;
        line_read    = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            burst_rdata = {$urandom, $urandom};
            burst_resp  = 1'b1;
            @(posedge clk); #1;
        end
        burst_resp = 1'b0;
        rst_n      = 1'b0;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        line_read = 1'b0;
        checkOutput("abort_outputs", {burst_read, burst_write, line_resp}, 0);
        checkOutput("abort_rdata", line_rdata, 0);
        checkOutput("abort_address", burst_address, 0);
        checkOutput("abort_wdata", burst_wdata, 0);
        applyStimulus(1'b0, 1'b0, $urandom, '0, 1'b0, 0, 2);

        for (int n = 0; n < 20; n++) begin
            applyStimulus(1'($urandom_range(1, 0)), 1'b0, $urandom, randLine(), 1'b0, 0, 2);
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("txn_drained", txnQ.size(), 0);
        checkOutput("beats_drained", beatQ.size(), 0);
        checkOutput("final_proto_err", proto_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 SHALL have parameter s_line, default 256: width of a cache line in bits.
REQ-002 SHALL have parameter s_burst, default 64: width of one memory beat in bits.
REQ-003 SHALL have derived parameter n_beats = s_line/s_burst, default 4.
REQ-004 clk  input  1  the only clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 line_read  input  1  line read request from the cache downstream port; held high until line_resp.
REQ-007 line_write  input  1  line write request from the cache downstream port; held high until line_resp.
REQ-008 line_address  input  32  byte address of the request.
REQ-009 line_wdata  input  s_line  line to be written.
REQ-010 line_rdata  output  s_line  assembled read line.
REQ-011 line_resp  output  1  one-cycle completion pulse.
REQ-012 burst_rdata  input  s_burst  memory read beat.
REQ-013 burst_resp  input  1  beat handshake from memory.
REQ-014 burst_wdata  output  s_burst  memory write beat.
REQ-015 burst_address  output  32  line-aligned memory address.
REQ-016 burst_read  output  1  memory read request.
REQ-017 burst_write  output  1  memory write request.
REQ-018 proto_err  output  1  sticky protocol-error flag (see Configuration).

Function
REQ-019 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-020 In IDLE, line_write=1 SHALL move to WRITE; line_read=1 with line_write=0 SHALL move to READ; write wins if both are high.
REQ-021 On leaving IDLE, SHALL latch line_address with the low log2(s_line/8) bits cleared into burst_address, latch line_wdata, and clear the beat counter.
REQ-022 burst_read SHALL be 1 exactly while in READ; burst_write SHALL be 1 exactly while in WRITE; both SHALL be driven from state only.
REQ-023 In READ, each cycle with burst_resp=1 SHALL store burst_rdata into line_rdata slice [cnt*s_burst +: s_burst] and increment cnt.
REQ-024 Cycles with burst_resp=0 SHALL hold all state; there is no timeout.
REQ-025 In WRITE, burst_wdata SHALL equal latched-line slice [cnt*s_burst +: s_burst]; on burst_resp=1 cnt SHALL increment.
REQ-026 When the beat with cnt=n_beats-1 is accepted, the FSM SHALL go to DONE on the same edge.
REQ-027 In DONE, line_resp SHALL be 1 for exactly one cycle, followed by an unconditional move to IDLE.
REQ-028 line_rdata SHALL hold its value from DONE until the next read overwrites its first beat.
REQ-029 Minimum latency from acceptance edge to line_resp SHALL be n_beats+1 cycles: accept at edge 0, beats on cycles 1..4, line_resp in cycle 5.
REQ-030 burst_resp while in IDLE or DONE SHALL be ignored for data and counting.
REQ-031 Request inputs changing mid-transaction SHALL be ignored; only latched values are used.
REQ-032 The counter SHALL be log2(n_beats) bits and SHALL wrap to 0 on the final beat.

Reset
REQ-033 rst_n=0 at a rising edge SHALL force IDLE, cnt=0, line_rdata=0, burst_address=0, latched wdata=0, and proto_err=0.
REQ-034 After that edge, line_resp, burst_read and burst_write SHALL be 0.
REQ-035 Reset during READ or WRITE SHALL abandon the burst with no line_resp.

Configuration
REQ-036 Macro ADAPTOR_PROTOCOL_CHECK_EN defined: proto_err SHALL set and stay set until reset on any of the following: burst_resp=1 in IDLE or DONE; line_read=1 and line_write=1 together in IDLE; line_read or line_write deasserted in READ or WRITE.
REQ-037 Macro ADAPTOR_PROTOCOL_CHECK_EN undefined: proto_err SHALL be tied to 0, with no checker logic present.

Verification
REQ-038 Read line_address=0x0000_1234 with beats 0x11..,0x22..,0x33..,0x44.. on consecutive cycles -> burst_address=0x0000_1220, line_rdata={0x44..,0x33..,0x22..,0x11..}, line_resp in cycle 5.
REQ-039 Write line_wdata=256'h{D,C,B,A} with burst_resp pulsed every other cycle -> burst_wdata sequence A,B,C,D, each held until accepted, then one line_resp.
REQ-040 line_read and line_write both high in IDLE -> WRITE taken, burst_read never 1, and proto_err=1 when the macro is defined.
REQ-041 rst_n low after 2 read beats -> next cycle IDLE and all outputs 0; a following read completes with correct data and cnt restarting at 0.
REQ-042 Stray burst_resp in IDLE -> no state change, line_rdata unchanged, proto_err=1 only with ADAPTOR_PROTOCOL_CHECK_EN.
REQ-043 Back-to-back read then write -> each gets exactly one line_resp, with one IDLE cycle between them.
